// File: rtl/hdmi_video_pkg.sv
// Shared definitions for the HDMI video pipe.
//   mode_e    : content modes selected through mode_req / reported on mode_active.
//   bar_color : colour-bar pixel for a bar index 0..7. The result is
//               MAX_DATA_W wide with the low data_w bits populated (R:G:B,
//               MSB channel first); callers cast it down to their pixel width.
package hdmi_video_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  localparam int MAX_DATA_W = 96;

  function automatic logic [MAX_DATA_W-1:0] bar_color(input logic [2:0] idx,
                                                       input int data_w);
    logic [2:0]            rgb;
    logic [MAX_DATA_W-1:0] pix;
    int                    c;
    // rgb[2]=R, rgb[1]=G, rgb[0]=B; each channel is all-ones or all-zeros
    case (idx)
      3'd0:    rgb = 3'b111; // white
      3'd1:    rgb = 3'b110; // yellow
      3'd2:    rgb = 3'b011; // cyan
      3'd3:    rgb = 3'b010; // green
      3'd4:    rgb = 3'b101; // magenta
      3'd5:    rgb = 3'b100; // red
      3'd6:    rgb = 3'b001; // blue
      default: rgb = 3'b000; // black
    endcase
    c   = (data_w >= 3) ? data_w / 3 : 1;
    pix = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < 3 * c) pix[i] = rgb[2'(i / c)];
    end
    return pix;
  endfunction

endpackage

// File: rtl/hdmi_timing_meter.sv
// Frame-start detection, active-resolution measurement and timing lock.
//   clk, reset_n    : pixel clock, synchronous active-low reset
//   de, vsync       : raw input timing (same samples that enter the pipeline)
//   fs              : combinational frame-start event; high in the cycle whose
//                     clock edge samples the first vsync=1 after a vsync=0
//   de_rise         : combinational DE rising-edge event at the input
//   frame_strobe    : registered one-cycle pulse following fs
//   h_active        : DE-high pixels of the last line of the previous frame
//   v_active        : DE lines of the previous frame
//   bar_w           : colour-bar width (h_active >> 3), latched at fs
//   locked          : registered, high after LOCK_FRAMES matching frames
module hdmi_timing_meter #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             de,
  input  logic             vsync,
  output logic             fs,
  output logic             de_rise,
  output logic             frame_strobe,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic [CNT_W-1:0] bar_w,
  output logic             locked
);

  localparam int MW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_FRAMES);

  logic             vs_d;
  logic             de_d;
  logic             de_fall;
  logic             frame_valid; // a full frame has been observed since reset
  logic [CNT_W-1:0] x_cnt;
  logic [CNT_W-1:0] y_cnt;
  logic [CNT_W-1:0] line_w;
  logic [CNT_W-1:0] h_next;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_next;

  always_comb begin
    fs         = vsync & ~vs_d;
    de_rise    = de & ~de_d;
    de_fall    = ~de & de_d;
    // bar width follows the h_active value that is in force after this fs
    h_next     = frame_valid ? line_w : h_active;
    match_next = match_cnt;
    if (frame_valid) begin
      // equality with a nonzero new size implies the stored size is nonzero too
      if ((line_w == h_active) && (y_cnt == v_active) &&
          (line_w != '0) && (y_cnt != '0)) begin
        match_next = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + 1'b1;
      end else begin
        match_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vs_d         <= 1'b0;
      de_d         <= 1'b0;
      frame_valid  <= 1'b0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      line_w       <= '0;
      h_active     <= '0;
      v_active     <= '0;
      bar_w        <= '0;
      match_cnt    <= '0;
      locked       <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      vs_d         <= vsync;
      de_d         <= de;
      frame_strobe <= fs;

      if (de) begin
        if (de_rise)               x_cnt <= CNT_W'(1);
        else if (x_cnt != CNT_MAX) x_cnt <= x_cnt + 1'b1;
      end
      if (de_fall) line_w <= x_cnt;

      // fs clears first; a coincident DE rise is then the frame's first line
      if (fs)                              y_cnt <= de_rise ? CNT_W'(1) : '0;
      else if (de_rise && y_cnt != CNT_MAX) y_cnt <= y_cnt + 1'b1;

      if (fs) begin
        frame_valid <= 1'b1;
        bar_w       <= h_next >> 3;
        if (frame_valid) begin
          h_active  <= line_w;
          v_active  <= y_cnt;
          match_cnt <= match_next;
          locked    <= (match_next == MATCH_MAX);
        end
      end
    end
  end

endmodule

// File: rtl/hdmi_video_pipe.sv
// HDMI RX-to-TX video retiming pipe with test-content substitution.
//   HDMI_RX_CLK, reset_n        : pixel clock, synchronous active-low reset
//   rx_de/rx_hsync/rx_vsync     : input timing
//   rx_data                     : input pixel (R:G:B, MSB channel first)
//   mode_req                    : requested mode, taken only at frame start
//   fill_color                  : pixel used in solid-fill mode
//   tx_de/tx_hsync/tx_vsync     : timing delayed by PIPE_STAGES cycles
//   tx_data                     : pixel aligned with tx_de
//   mode_active                 : mode currently applied at the pipeline input
//   h_active/v_active           : measured size of the previous frame
//   locked                      : timing stable over LOCK_FRAMES frames
//   frame_strobe                : one-cycle pulse per frame start
// Substitution happens as pixels enter the first stage, so pixels already in
// the pipe keep whatever mode they entered with.
module hdmi_video_pipe
  import hdmi_video_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              HDMI_RX_CLK,
  input  logic              reset_n,
  input  logic              rx_de,
  input  logic              rx_hsync,
  input  logic              rx_vsync,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [1:0]        mode_req,
  input  logic [DATA_W-1:0] fill_color,
  output logic              tx_de,
  output logic              tx_hsync,
  output logic              tx_vsync,
  output logic [DATA_W-1:0] tx_data,
  output logic [1:0]        mode_active,
  output logic [CNT_W-1:0]  h_active,
  output logic [CNT_W-1:0]  v_active,
  output logic              locked,
  output logic              frame_strobe
);

  typedef struct packed {
    logic              de;
    logic              hs;
    logic              vs;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t           pipe_q [PIPE_STAGES];
  stage_t           stage_in;
  mode_e            mode_q;
  logic             fs;
  logic             de_rise;
  logic [CNT_W-1:0] bar_w;
  logic [2:0]       bar_idx;
  logic [CNT_W-1:0] bar_cnt;
  logic [2:0]       cur_idx;
  logic [CNT_W-1:0] cur_cnt;
  logic             bar_end;
  logic [DATA_W-1:0] sub_data;

  hdmi_timing_meter #(
    .CNT_W       (CNT_W),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_meter (
    .clk          (HDMI_RX_CLK),
    .reset_n      (reset_n),
    .de           (rx_de),
    .vsync        (rx_vsync),
    .fs           (fs),
    .de_rise      (de_rise),
    .frame_strobe (frame_strobe),
    .h_active     (h_active),
    .v_active     (v_active),
    .bar_w        (bar_w),
    .locked       (locked)
  );

  // Bar position of the pixel currently at the input; a DE rise restarts it.
  always_comb begin
    cur_idx  = de_rise ? 3'd0 : bar_idx;
    cur_cnt  = de_rise ? '0 : bar_cnt;
    bar_end  = (bar_w != '0) && (cur_cnt == bar_w - 1'b1);
    sub_data = '0;
    case (mode_q)
      MODE_PASS:  sub_data = rx_data;
      MODE_BARS:  sub_data = rx_de ? DATA_W'(bar_color(cur_idx, DATA_W)) : '0;
      MODE_SOLID: sub_data = rx_de ? fill_color : '0;
      default:    sub_data = '0;
    endcase
    stage_in.de   = rx_de;
    stage_in.hs   = rx_hsync;
    stage_in.vs   = rx_vsync;
    stage_in.data = sub_data;
  end

  always_ff @(posedge HDMI_RX_CLK) begin
    if (!reset_n) begin
      mode_q  <= MODE_PASS;
      bar_idx <= 3'd0;
      bar_cnt <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
    end else begin
      if (fs) mode_q <= mode_e'(mode_req);

      if (rx_de) begin
        if (bar_end) begin
          bar_cnt <= '0;
          bar_idx <= (cur_idx != 3'd7) ? cur_idx + 3'd1 : cur_idx;
        end else begin
          // with bar_w==0 the index never moves, so keep the counter parked
          bar_cnt <= (bar_w == '0) ? '0 : cur_cnt + 1'b1;
          bar_idx <= cur_idx;
        end
      end

      pipe_q[0] <= stage_in;
      for (int i = 1; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tx_de       = pipe_q[PIPE_STAGES-1].de;
  assign tx_hsync    = pipe_q[PIPE_STAGES-1].hs;
  assign tx_vsync    = pipe_q[PIPE_STAGES-1].vs;
  assign tx_data     = pipe_q[PIPE_STAGES-1].data;
  assign mode_active = mode_q;

endmodule

// File: tb/tb_hdmi_video_pipe.sv
module tb_hdmi_video_pipe;

  localparam int DW = 24;
  localparam int PS = 2;
  localparam logic [DW-1:0] BLANK_FILL = 24'hA5A5A5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          rx_de, rx_hsync, rx_vsync;
  logic [DW-1:0] rx_data, fill_color;
  logic [1:0]    mode_req;

  logic          tx_de, tx_hsync, tx_vsync;
  logic [DW-1:0] tx_data;
  logic [1:0]    mode_active;
  logic [11:0]   h_active, v_active;
  logic          locked, frame_strobe;

  logic          s_tx_de, s_tx_hsync, s_tx_vsync;
  logic [DW-1:0] s_tx_data;
  logic [1:0]    s_mode_active;
  logic [3:0]    s_h_active, s_v_active;
  logic          s_locked, s_frame_strobe;

  hdmi_video_pipe #(.DATA_W(DW), .PIPE_STAGES(PS), .CNT_W(12), .LOCK_FRAMES(2)) dut (
    .HDMI_RX_CLK(clk), .reset_n(reset_n),
    .rx_de(rx_de), .rx_hsync(rx_hsync), .rx_vsync(rx_vsync), .rx_data(rx_data),
    .mode_req(mode_req), .fill_color(fill_color),
    .tx_de(tx_de), .tx_hsync(tx_hsync), .tx_vsync(tx_vsync), .tx_data(tx_data),
    .mode_active(mode_active), .h_active(h_active), .v_active(v_active),
    .locked(locked), .frame_strobe(frame_strobe)
  );

  // narrow-counter instance for saturation
  hdmi_video_pipe #(.DATA_W(DW), .PIPE_STAGES(PS), .CNT_W(4), .LOCK_FRAMES(2)) dut_sat (
    .HDMI_RX_CLK(clk), .reset_n(reset_n),
    .rx_de(rx_de), .rx_hsync(rx_hsync), .rx_vsync(rx_vsync), .rx_data(rx_data),
    .mode_req(mode_req), .fill_color(fill_color),
    .tx_de(s_tx_de), .tx_hsync(s_tx_hsync), .tx_vsync(s_tx_vsync), .tx_data(s_tx_data),
    .mode_active(s_mode_active), .h_active(s_h_active), .v_active(s_v_active),
    .locked(s_locked), .frame_strobe(s_frame_strobe)
  );

  // ---------------- scoreboard state ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [DW+2:0] exp_q[$];
  logic [1:0]    exp_mode;
  logic          prev_vs, prev_de;
  int            line_px;
  int            exp_bar_w;
  logic [DW-1:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    check("rst_tx_de",        32'(tx_de),        32'd0);
    check("rst_tx_hsync",     32'(tx_hsync),     32'd0);
    check("rst_tx_vsync",     32'(tx_vsync),     32'd0);
    check("rst_tx_data",      32'(tx_data),      32'd0);
    check("rst_mode_active",  32'(mode_active),  32'd0);
    check("rst_h_active",     32'(h_active),     32'd0);
    check("rst_v_active",     32'(v_active),     32'd0);
    check("rst_locked",       32'(locked),       32'd0);
    check("rst_frame_strobe", 32'(frame_strobe), 32'd0);
    reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back('0); // stage two still holds its reset value
    prev_vs  = 1'b0;
    prev_de  = 1'b0;
    exp_mode = 2'd0;
    line_px  = 0;
  endtask

  // One input cycle: expected output pixel derived from the bench's mode.
  task automatic drive(input logic de, input logic hs, input logic vs, input logic [DW-1:0] d);
    logic [DW-1:0] e;
    logic          rise;
    int            idx;
    logic [DW+2:0] want;
    logic [DW+2:0] got;
    rise = vs & ~prev_vs;
    if (de) line_px = prev_de ? line_px + 1 : 0;
    idx = (exp_bar_w == 0) ? 0 : line_px / exp_bar_w;
    if (idx > 7) idx = 7;
    case (exp_mode)
      2'd0:    e = d;
      2'd1:    e = de ? bar_tab[idx] : '0;
      2'd2:    e = de ? fill_color : '0;
      default: e = '0;
    endcase
    rx_de = de; rx_hsync = hs; rx_vsync = vs; rx_data = d;
    exp_q.push_back({de, hs, vs, e});
    tick();
    if (rise) exp_mode = mode_req;
    prev_vs = vs;
    prev_de = de;
    check("frame_strobe", 32'(frame_strobe), 32'(rise));
    check("mode_active",  32'(mode_active),  32'(exp_mode));
    if (exp_q.size() == PS) begin
      want = exp_q.pop_front();
      got  = {tx_de, tx_hsync, tx_vsync, tx_data};
      check("tx_bus", 32'(got), 32'(want));
    end
  endtask

  task automatic frame(input int w, input int lines, input logic [DW-1:0] base,
                       input int chg_line, input logic [1:0] chg_mode, input int rst_line);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, BLANK_FILL);
    drive(1'b0, 1'b0, 1'b0, BLANK_FILL);
    for (int l = 0; l < lines; l++) begin
      if (l == chg_line) mode_req = chg_mode;
      drive(1'b0, 1'b1, 1'b0, BLANK_FILL);
      drive(1'b0, 1'b1, 1'b0, BLANK_FILL);
      drive(1'b0, 1'b0, 1'b0, BLANK_FILL);
      for (int p = 0; p < w; p++) begin
        if (l == rst_line && p == w / 2) do_reset();
        drive(1'b1, 1'b0, 1'b0, base + DW'(l * w + p));
      end
      drive(1'b0, 1'b0, 1'b0, BLANK_FILL);
      drive(1'b0, 1'b0, 1'b0, BLANK_FILL);
    end
  endtask

  task automatic check_meas(input string tag, input int h, input int v, input logic lk);
    check({tag, "_h_active"}, 32'(h_active), 32'(h));
    check({tag, "_v_active"}, 32'(v_active), 32'(v));
    check({tag, "_locked"},   32'(locked),   32'(lk));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    rx_de = 1'b0; rx_hsync = 1'b0; rx_vsync = 1'b0; rx_data = '0;
    mode_req = 2'd0; fill_color = '0; exp_bar_w = 0;
    exp_mode = 2'd0; prev_vs = 1'b0; prev_de = 1'b0; line_px = 0;
    do_reset();

    // passthrough, measurement and lock
    frame(16, 4, 24'h000100, -1, 2'd0, -1);
    check_meas("f1", 0, 0, 1'b0);
    frame(16, 4, 24'h010000, -1, 2'd0, -1);
    check_meas("f2", 16, 4, 1'b0);
    check("sat_h_active_f2", 32'(s_h_active), 32'd15);
    check("sat_v_active_f2", 32'(s_v_active), 32'd4);
    frame(16, 4, 24'h020000, -1, 2'd0, -1);
    check_meas("f3", 16, 4, 1'b0);
    frame(16, 4, 24'h030000, -1, 2'd0, -1);
    check_meas("f4", 16, 4, 1'b1);
    frame(15, 4, 24'h040000, -1, 2'd0, -1);
    check_meas("f5", 16, 4, 1'b1);
    frame(16, 4, 24'h050000, -1, 2'd0, -1);
    check_meas("f6", 15, 4, 1'b0);

    // bars requested mid-frame, applied at next frame start
    frame(16, 4, 24'h060000, 2, 2'd1, -1);
    exp_bar_w  = 2;
    fill_color = 24'h123456;
    frame(16, 4, 24'h070000, 1, 2'd2, -1);  // colour bars, 2 px each
    frame(16, 4, 24'h080000, 1, 2'd3, -1);  // solid fill
    check_meas("f9", 16, 4, 1'b1);
    frame(16, 4, 24'h090000, 3, 2'd1, -1);  // blank
    check_meas("f10", 16, 4, 1'b1);

    // narrow frames: first still uses bar_w 2, second has bar_w 0 (all white)
    frame(6, 2, 24'h0A0000, -1, 2'd1, -1);
    exp_bar_w = 0;
    frame(6, 2, 24'h0B0000, 1, 2'd0, -1);
    check_meas("f12", 6, 2, 1'b0);

    // reset in the middle of an active line
    frame(16, 4, 24'h0C0000, -1, 2'd0, 1);
    frame(16, 4, 24'h0D0000, -1, 2'd0, -1);
    check_meas("post_rst_fs1", 0, 0, 1'b0);
    frame(16, 4, 24'h0E0000, -1, 2'd0, -1);
    check_meas("post_rst_fs2", 16, 4, 1'b0);

    // 20-pixel lines: wide counter measures 20, 4-bit counter saturates
    frame(20, 2, 24'h0F0000, -1, 2'd0, -1);
    frame(16, 2, 24'h100000, -1, 2'd0, -1);
    check_meas("wide", 20, 2, 1'b0);
    check("sat_h_active_20", 32'(s_h_active), 32'd15);
    check("sat_v_active_20", 32'(s_v_active), 32'd2);

    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no end of sequence, expected finish");
    $fatal(1);
  end

endmodule
